// File: rtl/alarm_time_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module     : alarm_time_ctrl_if
//  Description: Button/tick inputs and time/alarm display outputs of the
//               alarm clock time-keeping controller.
//  Revision   : 1.0 - initial release
// ============================================================================
interface alarm_time_ctrl_if;
    logic       tick;
    logic       mode_btn;
    logic       up_btn;
    logic       stop_btn;
    logic       alarm_en;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic [2:0] mode;
    logic       ringing;
    logic       sec_restart;

    // Stimulus side: drives pulses and the arm level, observes the display
    modport master (
        output tick, mode_btn, up_btn, stop_btn, alarm_en,
        input  hours, minutes, seconds, alarm_hours, alarm_minutes,
               mode, ringing, sec_restart
    );

    // Controller side
    modport slave (
        input  tick, mode_btn, up_btn, stop_btn, alarm_en,
        output hours, minutes, seconds, alarm_hours, alarm_minutes,
               mode, ringing, sec_restart
    );
endinterface
`default_nettype wire

// File: rtl/alarm_time_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : alarm_time_ctrl
//  Description: HH:MM:SS time keeping, user set-modes, alarm with snooze and
//               ring timeout, and second-counter re-phasing on time set.
//  Revision   : 1.0 - initial release
// ============================================================================
module alarm_time_ctrl #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  wire logic         clk,
    input  wire logic         reset_sync_n,
    alarm_time_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_H  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_AH = 3'd3,
        ST_SET_AM = 3'd4
    } mode_t;

    localparam logic [6:0] c_snooze_min = 7'(SNOOZE_MIN);
    localparam logic [7:0] c_ring_last  = 8'(RING_TIMEOUT_S - 1);

    mode_t      r_mode,          w_mode_nxt;
    logic [4:0] r_hours,         w_hours_nxt;
    logic [5:0] r_minutes,       w_minutes_nxt;
    logic [5:0] r_seconds,       w_seconds_nxt;
    logic [4:0] r_alarm_hours,   w_alarm_hours_nxt;
    logic [5:0] r_alarm_minutes, w_alarm_minutes_nxt;
    logic       r_ringing,       w_ringing_nxt;
    logic       r_sec_restart,   w_sec_restart_nxt;
    logic       r_snz_active,    w_snz_active_nxt;
    logic [4:0] r_snz_hours,     w_snz_hours_nxt;
    logic [5:0] r_snz_minutes,   w_snz_minutes_nxt;
    logic [7:0] r_ring_cnt,      w_ring_cnt_nxt;

    function automatic logic [4:0] inc24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    // Time only runs outside the time-set modes; everything else builds on
    // the post-tick value so a same-cycle increment adds to any carry.
    logic       w_tick_adv;
    logic       w_sec_wrap, w_min_wrap;
    logic [4:0] w_t_hours;
    logic [5:0] w_t_minutes, w_t_seconds;

    assign w_tick_adv  = bus.tick && (r_mode == ST_RUN || r_mode == ST_SET_AH ||
                                      r_mode == ST_SET_AM);
    assign w_sec_wrap  = (r_seconds == 6'd59);
    assign w_min_wrap  = (r_minutes == 6'd59);
    assign w_t_seconds = w_tick_adv ? inc60(r_seconds) : r_seconds;
    assign w_t_minutes = (w_tick_adv && w_sec_wrap) ? inc60(r_minutes) : r_minutes;
    assign w_t_hours   = (w_tick_adv && w_sec_wrap && w_min_wrap) ? inc24(r_hours) : r_hours;

    // Snooze target: current time plus SNOOZE_MIN, carrying into the hour
    logic [6:0] w_snz_sum;
    logic       w_snz_carry;
    logic [5:0] w_snz_min_calc;
    logic [4:0] w_snz_hr_calc;

    assign w_snz_sum      = {1'b0, w_t_minutes} + c_snooze_min;
    assign w_snz_carry    = (w_snz_sum >= 7'd60);
    assign w_snz_min_calc = w_snz_carry ? 6'(w_snz_sum - 7'd60) : w_snz_sum[5:0];
    assign w_snz_hr_calc  = w_snz_carry ? inc24(w_t_hours) : w_t_hours;

    // Triggers only fire on a tick-driven update, never on manual edits
    logic w_at_top, w_alarm_hit, w_snz_hit;

    assign w_at_top    = w_tick_adv && (w_t_seconds == 6'd0);
    assign w_alarm_hit = w_at_top && (w_t_hours == r_alarm_hours) &&
                         (w_t_minutes == r_alarm_minutes);
    assign w_snz_hit   = w_at_top && r_snz_active && (w_t_hours == r_snz_hours) &&
                         (w_t_minutes == r_snz_minutes);

    // Next-state: timeout, triggers, prioritised buttons, then disarm override
    always_comb begin
        w_mode_nxt          = r_mode;
        w_hours_nxt         = w_t_hours;
        w_minutes_nxt       = w_t_minutes;
        w_seconds_nxt       = w_t_seconds;
        w_alarm_hours_nxt   = r_alarm_hours;
        w_alarm_minutes_nxt = r_alarm_minutes;
        w_ringing_nxt       = r_ringing;
        w_sec_restart_nxt   = 1'b0;
        w_snz_active_nxt    = r_snz_active;
        w_snz_hours_nxt     = r_snz_hours;
        w_snz_minutes_nxt   = r_snz_minutes;
        w_ring_cnt_nxt      = r_ring_cnt;

        if (r_ringing && bus.tick) begin
            if (r_ring_cnt == c_ring_last) begin
                w_ringing_nxt = 1'b0;
            end else begin
                w_ring_cnt_nxt = r_ring_cnt + 8'd1;
            end
        end

        if (!r_ringing && bus.alarm_en && (w_alarm_hit || w_snz_hit)) begin
            w_ringing_nxt  = 1'b1;
            w_ring_cnt_nxt = 8'd0;
            if (w_snz_hit) begin
                w_snz_active_nxt = 1'b0;
            end
        end

        if (bus.stop_btn) begin
            w_ringing_nxt    = 1'b0;
            w_snz_active_nxt = 1'b0;
        end else if (bus.mode_btn) begin
            if (r_ringing) begin
                w_ringing_nxt    = 1'b0;
                w_snz_active_nxt = 1'b0;
            end else begin
                case (r_mode)
                    ST_RUN: begin
                        w_mode_nxt       = ST_SET_H;
                        w_seconds_nxt    = 6'd0;
                        w_ringing_nxt    = 1'b0;
                        w_snz_active_nxt = 1'b0;
                    end
                    ST_SET_H:  w_mode_nxt = ST_SET_M;
                    ST_SET_M: begin
                        w_mode_nxt        = ST_SET_AH;
                        w_sec_restart_nxt = 1'b1;
                    end
                    ST_SET_AH: w_mode_nxt = ST_SET_AM;
                    default:   w_mode_nxt = ST_RUN;
                endcase
            end
        end else if (bus.up_btn) begin
            if (r_ringing && r_mode != ST_SET_H && r_mode != ST_SET_M) begin
                w_ringing_nxt     = 1'b0;
                w_snz_active_nxt  = 1'b1;
                w_snz_hours_nxt   = w_snz_hr_calc;
                w_snz_minutes_nxt = w_snz_min_calc;
            end else begin
                case (r_mode)
                    ST_SET_H:  w_hours_nxt         = inc24(w_t_hours);
                    ST_SET_M:  w_minutes_nxt       = inc60(w_t_minutes);
                    ST_SET_AH: w_alarm_hours_nxt   = inc24(r_alarm_hours);
                    ST_SET_AM: w_alarm_minutes_nxt = inc60(r_alarm_minutes);
                    default:   ;
                endcase
            end
        end

        if (!bus.alarm_en) begin
            w_ringing_nxt    = 1'b0;
            w_snz_active_nxt = 1'b0;
        end

        if (!w_ringing_nxt) begin
            w_ring_cnt_nxt = 8'd0;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_sync_n) begin
            r_mode          <= ST_RUN;
            r_hours         <= 5'd0;
            r_minutes       <= 6'd0;
            r_seconds       <= 6'd0;
            r_alarm_hours   <= 5'd6;
            r_alarm_minutes <= 6'd0;
            r_ringing       <= 1'b0;
            r_sec_restart   <= 1'b0;
            r_snz_active    <= 1'b0;
            r_snz_hours     <= 5'd0;
            r_snz_minutes   <= 6'd0;
            r_ring_cnt      <= 8'd0;
        end else begin
            r_mode          <= w_mode_nxt;
            r_hours         <= w_hours_nxt;
            r_minutes       <= w_minutes_nxt;
            r_seconds       <= w_seconds_nxt;
            r_alarm_hours   <= w_alarm_hours_nxt;
            r_alarm_minutes <= w_alarm_minutes_nxt;
            r_ringing       <= w_ringing_nxt;
            r_sec_restart   <= w_sec_restart_nxt;
            r_snz_active    <= w_snz_active_nxt;
            r_snz_hours     <= w_snz_hours_nxt;
            r_snz_minutes   <= w_snz_minutes_nxt;
            r_ring_cnt      <= w_ring_cnt_nxt;
        end
    end

    assign bus.hours         = r_hours;
    assign bus.minutes       = r_minutes;
    assign bus.seconds       = r_seconds;
    assign bus.alarm_hours   = r_alarm_hours;
    assign bus.alarm_minutes = r_alarm_minutes;
    assign bus.mode          = r_mode;
    assign bus.ringing       = r_ringing;
    assign bus.sec_restart   = r_sec_restart;

endmodule
`default_nettype wire
